qpu_itcm_ctrl: RTL and testbench

- ICB responder in front of the single-port instruction TCM SRAM; the completing end of the IFU fetch bus.
- Accepts fetch commands on the cmd channel, reads the SRAM and returns instruction words in order on the rsp channel.
- Supports one fetch per cycle sustained, with a 2-entry response buffer that absorbs rsp back-pressure.
- Also owns a program-load write port used by the host to fill the ITCM; load writes have priority over fetches.

---
 rtl/qpu_itcm_ctrl.sv | 104 ++++++++++
 tb/tb_qpu_itcm_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_itcm_ctrl.sv
// ITCM controller: ICB fetch responder with a 2-entry in-order response buffer
// and a program-load write port that takes priority over fetches.
module qpu_itcm_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_AW     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] icb_cmd_addr,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic [DATA_WIDTH-1:0] icb_rsp_rdata,
  output logic                  itcm_nohold,
  input  logic                  ld_wr_valid,
  output logic                  ld_wr_ready,
  input  logic [RAM_AW-1:0]     ld_wr_addr,
  input  logic [DATA_WIDTH-1:0] ld_wr_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both 1;
  // valid never depends on ready, and cmd_ready depends only on registered
  // occupancy plus ld_wr_valid (never on icb_rsp_ready).

  logic                  inflight;
  logic [1:0]            cnt;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [2];

  logic [1:0] occupancy;
  logic       ld_act;
  logic       fetch_acc;
  logic       rsp_pop;
  logic       head_pop;
  logic       push;

  // Byte-offset and wrap bits of the fetch address are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icb_cmd_addr[ADDR_WIDTH-1:RAM_AW+2], icb_cmd_addr[1:0]};

  assign occupancy     = cnt + {1'b0, inflight};
  assign ld_wr_ready   = !rst;
  assign ld_act        = ld_wr_valid && !rst;
  assign icb_cmd_ready = !rst && !ld_wr_valid && (occupancy < 2'd2);
  assign fetch_acc     = icb_cmd_valid && icb_cmd_ready;

  assign icb_rsp_valid = (cnt != 2'd0) || inflight;
  assign icb_rsp_rdata = (cnt != 2'd0) ? fifo_mem[rd_ptr] : ram_dout;
  assign rsp_pop       = icb_rsp_valid && icb_rsp_ready;
  assign head_pop      = rsp_pop && (cnt != 2'd0);
  // The SRAM word is only bypassed when the buffer is empty; otherwise it queues.
  assign push          = inflight && !((cnt == 2'd0) && rsp_pop);

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ld_act) begin
      ram_cs    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = ld_wr_addr;
      ram_wdata = ld_wr_data;
    end else if (fetch_acc) begin
      ram_cs   = 1'b1;
      ram_addr = icb_cmd_addr[RAM_AW+1:2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      cnt         <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      itcm_nohold <= 1'b1;
    end else begin
      inflight <= fetch_acc;
      if (push)     wr_ptr <= ~wr_ptr;
      if (head_pop) rd_ptr <= ~rd_ptr;
      case ({push, head_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (ld_act)         itcm_nohold <= 1'b1;
      else if (fetch_acc) itcm_nohold <= 1'b0;
    end
  end

  // Buffer storage carries no reset; cnt alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_dout;
  end

endmodule

// File: tb/tb_qpu_itcm_ctrl.sv
// Bench for qpu_itcm_ctrl: SRAM model, directed scenarios, random traffic,
// and a queue-based reference of outstanding fetches checked every cycle.
module tb_qpu_itcm_ctrl;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          icb_cmd_valid = 1'b0;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr = '0;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready = 1'b0;
  logic [DW-1:0] icb_rsp_rdata;
  logic          itcm_nohold;
  logic          ld_wr_valid = 1'b0;
  logic          ld_wr_ready;
  logic [RW-1:0] ld_wr_addr = '0;
  logic [DW-1:0] ld_wr_data = '0;
  logic          ram_cs;
  logic          ram_we;
  logic [RW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_dout;

  qpu_itcm_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_AW(RW)) dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .itcm_nohold(itcm_nohold),
    .ld_wr_valid(ld_wr_valid), .ld_wr_ready(ld_wr_ready), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_dout(ram_dout)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [2**RW];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) sram[ram_addr] <= ram_wdata;
      else        ram_dout <= sram[ram_addr];
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] shadow [2**RW];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] log_q[$];
  int            log_cyc[$];
  logic          nohold_m = 1'b1;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  initial begin
    for (int i = 0; i < 2**RW; i++) begin
      sram[i]   <= 32'h5A5A_0000 ^ i;
      shadow[i]  = 32'h5A5A_0000 ^ i;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic exp_ready;
    logic exp_fetch;
    cyc++;
    if (rst) begin
      chk("rst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
      chk("rst_cmd_ready", {31'd0, icb_cmd_ready}, 32'd0);
      chk("rst_ram_cs",    {31'd0, ram_cs},        32'd0);
      chk("rst_ram_we",    {31'd0, ram_we},        32'd0);
      chk("rst_ld_ready",  {31'd0, ld_wr_ready},   32'd0);
      chk("rst_nohold",    {31'd0, itcm_nohold},   32'd1);
      exp_q.delete();
      nohold_m = 1'b1;
    end else begin
      exp_ready = !ld_wr_valid && (exp_q.size() < 2);
      exp_fetch = icb_cmd_valid && exp_ready;
      chk("cmd_ready", {31'd0, icb_cmd_ready}, {31'd0, exp_ready});
      chk("ld_ready",  {31'd0, ld_wr_ready},   32'd1);
      chk("rsp_valid", {31'd0, icb_rsp_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) chk("rsp_rdata", icb_rsp_rdata, exp_q[0]);
      chk("ram_cs", {31'd0, ram_cs}, {31'd0, ld_wr_valid || exp_fetch});
      if (ld_wr_valid) begin
        chk("ld_we",    {31'd0, ram_we},   32'd1);
        chk("ld_addr",  {20'd0, ram_addr}, {20'd0, ld_wr_addr});
        chk("ld_wdata", ram_wdata,         ld_wr_data);
      end else if (exp_fetch) begin
        chk("rd_we",   {31'd0, ram_we},   32'd0);
        chk("rd_addr", {20'd0, ram_addr}, {20'd0, icb_cmd_addr % 16'h4000 / 16'd4});
      end
      chk("nohold", {31'd0, itcm_nohold}, {31'd0, nohold_m});
      if (exp_q.size() > 0 && icb_rsp_ready) begin
        log_q.push_back(icb_rsp_rdata);
        log_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (exp_fetch) exp_q.push_back(shadow[icb_cmd_addr % 16'h4000 / 16'd4]);
      if (ld_wr_valid) shadow[ld_wr_addr] = ld_wr_data;
      if (ld_wr_valid)    nohold_m = 1'b1;
      else if (exp_fetch) nohold_m = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    icb_cmd_valid = 1'b0;
    ld_wr_valid   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    icb_rsp_ready = 1'b1;
    idle(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic done;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Preload words 0..7 through the load port.
    for (int i = 0; i < 8; i++) begin
      ld_wr_valid = 1'b1;
      ld_wr_addr  = RW'(i);
      ld_wr_data  = 32'h1000_0000 + i;
      step();
    end
    idle(1);

    // Back-to-back fetches, always ready.
    log_q.delete(); log_cyc.delete();
    icb_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      icb_cmd_valid = 1'b1;
      icb_cmd_addr  = AW'(i * 4);
      #1 chk("b2b_cmd_ready", {31'd0, icb_cmd_ready}, 32'd1);
      step();
    end
    idle(3);
    chk("b2b_count", log_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("b2b_word", log_q[i], 32'h1000_0000 + i);
      chk("b2b_nogap", log_cyc[i], log_cyc[0] + i);
    end

    // Stall: two fetches fill the buffer, third waits.
    drain();
    log_q.delete(); log_cyc.delete();
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = 16'h0008;
    #1 chk("stall_rdy0", {31'd0, icb_cmd_ready}, 32'd1);
    step();
    icb_cmd_addr = 16'h000C;
    #1 chk("stall_rdy1", {31'd0, icb_cmd_ready}, 32'd1);
    step();
    icb_cmd_addr = 16'h0010;
    #1 chk("stall_rdy2", {31'd0, icb_cmd_ready}, 32'd0);
    step();
    step();
    chk("stall_hold", {31'd0, icb_cmd_ready}, 32'd0);
    icb_rsp_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (icb_cmd_ready) done = 1'b1;
      step();
    end
    chk("stall_accept_timeout", {31'd0, done}, 32'd1);
    idle(4);
    chk("stall_count", log_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < log_q.size(); i++)
      chk("stall_order", log_q[i], 32'h1000_0002 + i);

    // Simultaneous push/pop with one word parked in the buffer.
    drain();
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = 16'h0000;
    step();
    icb_cmd_valid = 1'b0;
    step();
    icb_rsp_ready = 1'b1;
    icb_cmd_valid = 1'b1;
    for (int i = 1; i < 8; ) begin
      icb_cmd_addr = AW'(i * 4);
      #1;
      if (icb_cmd_ready) i++;
      step();
    end
    drain();

    // Load has priority over a same-cycle fetch.
    ld_wr_valid   = 1'b1;
    ld_wr_addr    = 12'h005;
    ld_wr_data    = 32'hCAFE_0005;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = 16'h0014;
    #1;
    chk("ldp_cmd_ready", {31'd0, icb_cmd_ready}, 32'd0);
    chk("ldp_ram_we",    {31'd0, ram_we},        32'd1);
    step();
    ld_wr_valid = 1'b0;
    #1;
    chk("ldp_nohold_set", {31'd0, itcm_nohold}, 32'd1);
    step();
    icb_cmd_valid = 1'b0;
    #1;
    chk("ldp_nohold_clr", {31'd0, itcm_nohold},   32'd0);
    chk("ldp_rsp_valid",  {31'd0, icb_rsp_valid}, 32'd1);
    chk("ldp_rdata",      icb_rsp_rdata,          32'hCAFE_0005);
    drain();

    // Address wrap and ignored byte offset.
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = 16'h4004;
    #1 chk("wrap_4004", {20'd0, ram_addr}, 32'h001);
    step();
    icb_cmd_addr = 16'h0003;
    #1 chk("wrap_0003", {20'd0, ram_addr}, 32'h000);
    step();
    drain();

    // Random traffic; loads stay clear of the words used by later pins.
    for (int i = 0; i < 400; i++) begin
      icb_cmd_valid = ($urandom_range(0, 99) < 70);
      icb_cmd_addr  = AW'($urandom_range(0, 16'hFFFF));
      icb_rsp_ready = ($urandom_range(0, 99) < 60);
      ld_wr_valid   = ($urandom_range(0, 99) < 15);
      ld_wr_addr    = RW'($urandom_range(16, 2**RW - 1));
      ld_wr_data    = $urandom;
      step();
    end
    drain();

    // Asynchronous reset with the buffer full.
    icb_rsp_ready = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = 16'h0000;
    step();
    icb_cmd_addr = 16'h0004;
    step();
    icb_cmd_valid = 1'b0;
    step();
    chk("pre_rst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
    chk("async_cmd_ready", {31'd0, icb_cmd_ready}, 32'd0);
    step();
    step();
    rst = 1'b0;
    icb_rsp_ready = 1'b1;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = 16'h0008;
    #1 chk("post_rst_ready", {31'd0, icb_cmd_ready}, 32'd1);
    step();
    icb_cmd_valid = 1'b0;
    #1;
    chk("post_rst_valid", {31'd0, icb_rsp_valid}, 32'd1);
    chk("post_rst_rdata", icb_rsp_rdata,          32'h1000_0002);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
